// File: rtl/instr_mem_loadable_if.sv
// Bus bundle between the instruction memory and its users: boot-load
// write port, fetch request/response and status.
interface instr_mem_loadable_if #(
    parameter int XLEN = 32,
    parameter int AW   = 6
);
    logic            load_en;
    logic [AW-1:0]   load_addr;
    logic [31:0]     load_data;
    logic            load_done;
    logic            fetch_req;
    logic [XLEN-1:0] fetch_addr;
    logic            fetch_stall;
    logic [31:0]     instr;
    logic            instr_valid;
    logic            fault;
    logic            busy;
    logic [AW:0]     load_count;

    modport master (
        output load_en, load_addr, load_data, load_done,
        output fetch_req, fetch_addr, fetch_stall,
        input  instr, instr_valid, fault, busy, load_count
    );

    modport slave (
        input  load_en, load_addr, load_data, load_done,
        input  fetch_req, fetch_addr, fetch_stall,
        output instr, instr_valid, fault, busy, load_count
    );
endinterface

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: written word-by-word during BOOT, then
// serves fetches with one cycle of registered latency, stall hold and
// fault reporting. Unloaded words always read as DEFAULT_INSTR.
module instr_mem_loadable #(
    parameter int              XLEN          = 32,
    parameter int              DEPTH         = 64,
    parameter logic [XLEN-1:0] BASE_ADDR     = '0,
    parameter logic [31:0]     DEFAULT_INSTR = 32'h0000_0013
) (
    input logic                 clk,
    input logic                 rst_n,
    instr_mem_loadable_if.slave bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [0:0]  ST_BOOT   = 1'b0;
    localparam logic [0:0]  ST_RUN    = 1'b1;
    localparam logic [AW:0] COUNT_MAX = (AW+1)'(DEPTH);

    logic [0:0]      state;
    logic [31:0]     mem [DEPTH];
    logic [DEPTH-1:0] loaded;
    logic [AW:0]     load_count;

    logic [XLEN-1:0] offset_p0;
    logic [XLEN-1:0] widx_p0;
    logic [AW-1:0]   idx_p0;
    logic            fault_p0;

    logic [31:0]     instr_p1;
    logic            vld_p1;
    logic            fault_p1;

    // Misaligned, below the base, or past the last word of the array.
    function automatic logic fetch_fault(input logic [XLEN-1:0] addr,
                                         input logic [XLEN-1:0] widx);
        return (addr[1:0] != 2'b00) || (addr < BASE_ADDR) ||
               (widx >= XLEN'(DEPTH));
    endfunction

    // Loaded-word counter never wraps past DEPTH.
    function automatic logic [AW:0] count_inc(input logic [AW:0] cnt);
        return (cnt == COUNT_MAX) ? cnt : cnt + (AW+1)'(1);
    endfunction

    // ---- stage p0: address decode of the incoming fetch ----
    // Full-width subtraction so addresses below the base wrap high and fault.
    always_comb begin
        offset_p0 = bus.fetch_addr - BASE_ADDR;
        widx_p0   = offset_p0 >> 2;
        idx_p0    = widx_p0[AW-1:0];
        fault_p0  = fetch_fault(bus.fetch_addr, widx_p0);
    end

    // Boot/run state, loaded bitmap and distinct-word counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_BOOT;
            loaded     <= '0;
            load_count <= '0;
        end else if (state == ST_BOOT) begin
            if (bus.load_en) begin
                loaded[bus.load_addr] <= 1'b1;
                if (!loaded[bus.load_addr])
                    load_count <= count_inc(load_count);
            end
            if (bus.load_done)
                state <= ST_RUN;
        end
    end

    // Storage array: written only during BOOT, never cleared by reset.
    always_ff @(posedge clk) begin
        if (rst_n && (state == ST_BOOT) && bus.load_en)
            mem[bus.load_addr] <= bus.load_data;
    end

    // ---- stage p1: registered fetch response ----
    // Stall freezes the whole response; an idle cycle drops valid/fault but
    // keeps the last instruction word on the bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_p1 <= DEFAULT_INSTR;
            vld_p1   <= 1'b0;
            fault_p1 <= 1'b0;
        end else if ((state == ST_RUN) && !bus.fetch_stall) begin
            if (bus.fetch_req) begin
                vld_p1   <= 1'b1;
                fault_p1 <= fault_p0;
                instr_p1 <= (fault_p0 || !loaded[idx_p0]) ? DEFAULT_INSTR
                                                          : mem[idx_p0];
            end else begin
                vld_p1   <= 1'b0;
                fault_p1 <= 1'b0;
            end
        end
    end

    assign bus.instr       = instr_p1;
    assign bus.instr_valid = vld_p1;
    assign bus.fault       = fault_p1;
    assign bus.busy        = (state == ST_BOOT);
    assign bus.load_count  = load_count;
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: directed loads and fetches, with expected
// fetch responses queued by the stimulus and checked by a monitor.
module tb_instr_mem_loadable;
    localparam int XLEN = 32;
    localparam int DEPTH = 64;
    localparam int AW = 6;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    instr_mem_loadable_if #(.XLEN(XLEN), .AW(AW)) bus ();

    instr_mem_loadable #(
        .XLEN(XLEN), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .DEFAULT_INSTR(NOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Monitor: every valid response consumes one queued expectation.
    always @(negedge clk) begin
        if (bus.instr_valid !== 1'b0) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: valid=%b instr=%h with no response expected",
                         bus.instr_valid, bus.instr);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.instr_valid !== 1'b1 || bus.instr !== e.instr || bus.fault !== e.fault) begin
                    failures++;
                    $display("FAIL fetch_resp: got valid=%b instr=%h fault=%b, want valid=1 instr=%h fault=%b",
                             bus.instr_valid, bus.instr, bus.fault, e.instr, e.fault);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.load_en     = 1'b0;
        bus.load_addr   = '0;
        bus.load_data   = '0;
        bus.load_done   = 1'b0;
        bus.fetch_req   = 1'b0;
        bus.fetch_addr  = '0;
        bus.fetch_stall = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic load(input logic [AW-1:0] idx, input logic [31:0] data, input logic done);
        bus.load_en   = 1'b1;
        bus.load_addr = idx;
        bus.load_data = data;
        bus.load_done = done;
        tick();
    endtask

    task automatic finish_boot();
        bus.load_done = 1'b1;
        tick();
    endtask

    // One fetch cycle; stall cycles pass the value expected to be held.
    task automatic fetch(input logic [31:0] addr, input logic stall,
                         input logic [31:0] exp_instr, input logic exp_fault);
        exp_t e;
        bus.fetch_req   = 1'b1;
        bus.fetch_addr  = addr;
        bus.fetch_stall = stall;
        e.instr = exp_instr;
        e.fault = exp_fault;
        q.push_back(e);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd1);
        chk("reset_valid", 32'(bus.instr_valid), 32'd0);
        chk("reset_fault", 32'(bus.fault), 32'd0);
        chk("reset_count", 32'(bus.load_count), 32'd0);
        chk("reset_instr", bus.instr, NOP);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic load then single fetch
        load(6'd0, 32'h0040_0093, 1'b0);
        load(6'd1, 32'h0080_0113, 1'b0);
        load(6'd2, 32'h0020_81B3, 1'b0);
        finish_boot();
        @(negedge clk);
        chk("run_busy", 32'(bus.busy), 32'd0);
        chk("count_three", 32'(bus.load_count), 32'd3);
        fetch(32'h04, 1'b0, 32'h0080_0113, 1'b0);

        // Back-to-back
        fetch(32'h00, 1'b0, 32'h0040_0093, 1'b0);
        fetch(32'h04, 1'b0, 32'h0080_0113, 1'b0);
        fetch(32'h08, 1'b0, 32'h0020_81B3, 1'b0);

        // Unloaded, misaligned, out of range, last word, wrapped address
        fetch(32'h0C, 1'b0, NOP, 1'b0);
        fetch(32'h06, 1'b0, NOP, 1'b1);
        fetch(32'h100, 1'b0, NOP, 1'b1);
        fetch(32'hFC, 1'b0, NOP, 1'b0);
        fetch(32'hFFFF_FFFC, 1'b0, NOP, 1'b1);

        // Stall holds the response, release delivers the stalled request
        fetch(32'h04, 1'b0, 32'h0080_0113, 1'b0);
        fetch(32'h08, 1'b1, 32'h0080_0113, 1'b0);
        fetch(32'h08, 1'b1, 32'h0080_0113, 1'b0);
        fetch(32'h08, 1'b1, 32'h0080_0113, 1'b0);
        fetch(32'h08, 1'b0, 32'h0020_81B3, 1'b0);
        fetch(32'h06, 1'b0, NOP, 1'b1);
        fetch(32'h00, 1'b1, NOP, 1'b1);
        fetch(32'h04, 1'b0, 32'h0080_0113, 1'b0);
        tick();
        @(negedge clk);
        chk("idle_valid", 32'(bus.instr_valid), 32'd0);
        chk("idle_instr_hold", bus.instr, 32'h0080_0113);

        // Load port is dead in RUN
        load(6'd3, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        chk("run_load_ignored", 32'(bus.load_count), 32'd3);
        fetch(32'h0C, 1'b0, NOP, 1'b0);

        // Mid-RUN reset with a fetch outstanding; BOOT behaviour
        do_reset();
        @(negedge clk);
        chk("rst_run_busy", 32'(bus.busy), 32'd1);
        chk("rst_run_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_run_count", 32'(bus.load_count), 32'd0);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h04;
        tick();
        load(6'd0, 32'h0010_0093, 1'b0);
        load(6'd0, 32'h00A0_0093, 1'b0);
        @(negedge clk);
        chk("reload_count", 32'(bus.load_count), 32'd1);
        load(6'd5, 32'h00C0_0193, 1'b1);
        @(negedge clk);
        chk("load_done_busy", 32'(bus.busy), 32'd0);
        chk("load_done_count", 32'(bus.load_count), 32'd2);
        fetch(32'h00, 1'b0, 32'h00A0_0093, 1'b0);
        fetch(32'h14, 1'b0, 32'h00C0_0193, 1'b0);
        fetch(32'h04, 1'b0, NOP, 1'b0);

        // Reset then empty program
        do_reset();
        finish_boot();
        @(negedge clk);
        chk("empty_count", 32'(bus.load_count), 32'd0);
        fetch(32'h00, 1'b0, NOP, 1'b0);

        // Fill every word, counter saturates at DEPTH
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            load(AW'(i), 32'h0000_0093 | (32'(i) << 20), 1'b0);
        load(6'd3, 32'h7FF0_0093, 1'b0);
        @(negedge clk);
        chk("full_count", 32'(bus.load_count), 32'd64);
        finish_boot();
        fetch(32'hFC, 1'b0, 32'h03F0_0093, 1'b0);
        fetch(32'h0C, 1'b0, 32'h7FF0_0093, 1'b0);
        fetch(32'h100, 1'b0, NOP, 1'b1);

        repeat (3) tick();
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
